// File: rtl/booth4_seq_mult_pkg.sv
// Shared types and constants for the radix-4 Booth sequential multiplier.
package booth4_seq_mult_pkg;

   localparam int unsigned DATA_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   // One radix-4 Booth digit retires two multiplier bits.
   function automatic int unsigned booth_iter(input int unsigned data_w);
      return data_w / 2;
   endfunction

endpackage

// File: rtl/booth4_seq_mult_if.sv
// Operand/product handshake bundle for booth4_seq_mult.
interface booth4_seq_mult_if
   import booth4_seq_mult_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_W-1:0]     A;
   logic [DATA_W-1:0]     B;
   logic                  out_valid;
   logic                  out_ready;
   logic [2*DATA_W-1:0]   P;
   logic                  busy;

   modport master (
      output in_valid, A, B, out_ready,
      input  in_ready, out_valid, P, busy
   );

   modport slave (
      input  in_valid, A, B, out_ready,
      output in_ready, out_valid, P, busy
   );
endinterface

// File: rtl/booth4_pp_gen.sv
// Radix-4 Booth partial-product generator: pp = digit(code) * a, exact at DATA_W+2 bits.
module booth4_pp_gen
   import booth4_seq_mult_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic [2:0]        code,
   input  logic [DATA_W-1:0] a,
   output logic [DATA_W+1:0] pp
);
   localparam int unsigned PP_W = DATA_W + 2;

   logic [PP_W-1:0] a_ext;
   logic [PP_W-1:0] a_x2;

   // Two guard bits keep -2A exact even for the most negative A.
   assign a_ext = {{2{a[DATA_W-1]}}, a};
   assign a_x2  = {a_ext[PP_W-2:0], 1'b0};

   // Booth digit selection
   always_comb begin
      pp = '0;
      case (code)
         3'b001, 3'b010: pp = a_ext;
         3'b011:         pp = a_x2;
         3'b100:         pp = -a_x2;
         3'b101, 3'b110: pp = -a_ext;
         default:        pp = '0;
      endcase
   end
endmodule

// File: rtl/booth4_seq_mult.sv
// Iterative signed multiplier retiring one radix-4 Booth digit per clock.
module booth4_seq_mult
   import booth4_seq_mult_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic            sys_clk,
   input  logic            sys_rst_n,
   booth4_seq_mult_if.slave bus
);
   localparam int unsigned ITER  = booth_iter(DATA_W);
   localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
   localparam int unsigned P_W   = 2 * DATA_W;
   localparam int unsigned PP_W  = DATA_W + 2;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

   state_e            state_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W:0]   b_sh_q;
   logic [P_W-1:0]    acc_q;
   logic [P_W-1:0]    acc_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [P_W-1:0]    p_q;
   logic              in_ready_q;
   logic              out_valid_q;
   logic              busy_q;
   logic [PP_W-1:0]   pp;
   logic [P_W-1:0]    pp_ext;

   booth4_pp_gen #(.DATA_W(DATA_W)) u_pp_gen (
      .code (b_sh_q[2:0]),
      .a    (a_q),
      .pp   (pp)
   );

   // Weighted partial product added into the running sum (wraps at 2*DATA_W bits).
   assign pp_ext = {{(P_W-PP_W){pp[PP_W-1]}}, pp};
   assign acc_d  = acc_q + (pp_ext << {cnt_q, 1'b0});

   // Control FSM with datapath registers and registered handshake outputs
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_sh_q      <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         p_q         <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  a_q        <= bus.A;
                  b_sh_q     <= {bus.B, 1'b0};
                  acc_q      <= '0;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= CALC;
               end
            end
            CALC: begin
               acc_q  <= acc_d;
               b_sh_q <= {{2{b_sh_q[DATA_W]}}, b_sh_q[DATA_W:2]};
               cnt_q  <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_LAST) begin
                  p_q         <= acc_d;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.P         = p_q;
   assign bus.busy      = busy_q;
endmodule

// File: tb/tb_booth4_seq_mult.sv
// Self-checking bench for booth4_seq_mult: behavioural timing/product model plus directed literals.
module tb_booth4_seq_mult;
   import booth4_seq_mult_pkg::*;

   localparam int unsigned W    = 16;
   localparam int unsigned ITER = booth_iter(W);

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   booth4_seq_mult_if #(.DATA_W(W)) bus ();

   booth4_seq_mult #(.DATA_W(W)) dut (
      .sys_clk   (clk),
      .sys_rst_n (rst_n),
      .bus       (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int n_acc   = 0;
   int n_res   = 0;

   // Behavioural model state: one operation in flight, product known at accept time.
   bit          m_busy = 1'b0;
   int          m_age  = 0;
   logic [31:0] m_p    = '0;
   logic [31:0] m_cur  = '0;
   logic [31:0] exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: timed out at %0t", name, $time);
   endtask

   function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
      int sa;
      int sb;
      sa = int'($signed(a));
      sb = int'($signed(b));
      return 32'(sa * sb);
   endfunction

   // Model update: accept in idle, product appears ITER cycles later, leaves on out_ready.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if (m_busy) n_acc--;
         m_busy = 1'b0;
         m_age  = 0;
         m_p    = '0;
         exp_q.delete();
      end else if (!m_busy) begin
         if (bus.in_valid === 1'b1) begin
            m_busy = 1'b1;
            m_age  = 0;
            m_cur  = ref_mul(bus.A, bus.B);
            exp_q.push_back(m_cur);
            n_acc++;
         end
      end else if (m_age < int'(ITER)) begin
         m_age++;
         if (m_age == int'(ITER)) m_p = m_cur;
      end else if (bus.out_ready === 1'b1) begin
         m_busy = 1'b0;
         check("order", 64'(bus.P), 64'(exp_q.pop_front()));
         n_res++;
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      check("in_ready",  64'(bus.in_ready),  64'(!m_busy));
      check("busy",      64'(bus.busy),      64'(m_busy));
      check("out_valid", 64'(bus.out_valid), 64'(m_busy && (m_age == int'(ITER))));
      check("P",         64'(bus.P),         64'(m_p));
   end

   task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                         input bit use_lit, input logic [31:0] lit,
                         input int stall, input bit noise, input bit chk_lat,
                         input bit rnd_ready);
      int cyc;
      cyc = 0;
      while (bus.in_ready !== 1'b1 && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
      end
      if (cyc >= 50) fail_now("wait_in_ready");
      bus.A        = a;
      bus.B        = b;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      cyc = 0;
      while (bus.out_valid !== 1'b1 && cyc < 50) begin
         if (noise) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.A        = 16'($urandom);
            bus.B        = 16'($urandom);
         end
         if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         cyc++;
      end
      if (cyc >= 50) fail_now("wait_out_valid");
      if (chk_lat) check("latency", 64'(cyc), 64'(ITER));
      bus.out_ready = 1'b0;
      for (int i = 0; i < stall; i++) begin
         if (noise) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.A        = 16'($urandom);
            bus.B        = 16'($urandom);
         end
         if (use_lit) check("P_hold", 64'(bus.P), 64'(lit));
         @(posedge clk); #1;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      if (use_lit) check("P_lit", 64'(bus.P), 64'(lit));
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check("in_ready_after", 64'(bus.in_ready), 64'(1));
      check("out_valid_after", 64'(bus.out_valid), 64'(0));
   endtask

   logic [15:0] corners [5];

   initial begin
      corners[0] = 16'h0000;
      corners[1] = 16'h0001;
      corners[2] = 16'hFFFF;
      corners[3] = 16'h7FFF;
      corners[4] = 16'h8000;
      bus.in_valid  = 1'b0;
      bus.A         = '0;
      bus.B         = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      check("rst_in_ready",  64'(bus.in_ready),  64'(1));
      check("rst_out_valid", 64'(bus.out_valid), 64'(0));
      check("rst_P",         64'(bus.P),         64'(0));
      check("rst_busy",      64'(bus.busy),      64'(0));

      run_op(16'd3,    16'd5,    1'b1, 32'h0000000F, 0, 1'b0, 1'b1, 1'b0);
      run_op(16'h8000, 16'h8000, 1'b1, 32'h40000000, 0, 1'b0, 1'b1, 1'b0);
      run_op(16'h7FFF, 16'h8000, 1'b1, 32'hC0008000, 1, 1'b0, 1'b1, 1'b0);
      run_op(16'hFFFF, 16'h0001, 1'b1, 32'hFFFFFFFF, 2, 1'b0, 1'b1, 1'b0);

      // Backpressure with in_valid noise during CALC and DONE.
      run_op(16'h0100, 16'h0010, 1'b1, 32'h00001000, 20, 1'b1, 1'b1, 1'b0);
      repeat (5) @(posedge clk);
      #1;

      // Abort mid-calculation, then a fresh operation.
      bus.A = 16'd5; bus.B = 16'd5; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("abort_busy",      64'(bus.busy),      64'(0));
      check("abort_out_valid", 64'(bus.out_valid), 64'(0));
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      check("abort_no_output", 64'(bus.out_valid), 64'(0));
      run_op(16'hFFF9, 16'd9, 1'b1, 32'hFFFFFFC1, 0, 1'b0, 1'b1, 1'b0);

      // Corner operand pairs.
      for (int i = 0; i < 5; i++)
         for (int j = 0; j < 5; j++)
            run_op(corners[i], corners[j], 1'b1, ref_mul(corners[i], corners[j]),
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1, 1'b1);

      // Random signed pairs with random stalls and noise.
      for (int k = 0; k < 3000; k++)
         run_op(16'($urandom), 16'($urandom), 1'b0, 32'h0,
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, 1'b1);

      repeat (3) @(posedge clk);
      #1;
      check("result_count", 64'(n_res), 64'(n_acc));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
